// File: rtl/pc_unit.sv
// pc_unit: program-counter register with next-PC selection for sequential
// fetch, sign-magnitude relative branches, absolute jumps and call/return
// through an internal return-address stack (RAS). Stack overflow and
// underflow are recorded in sticky error flags.
module pc_unit #(
  parameter int               WIDTH     = 16,
  parameter int               STEP      = 1,
  parameter int               RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [2:0]                     op,
  input  logic                           decr,
  input  logic [WIDTH-1:0]               diff,
  input  logic [WIDTH-1:0]               target,
  input  logic                           clr_err,
  output logic [WIDTH-1:0]               pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_full,
  output logic                           ras_empty,
  output logic                           err_ovf,
  output logic                           err_unf
);

  localparam int CW = $clog2(RAS_DEPTH+1);
  // Index width for the stack storage; ras_count needs one more value
  // (the "full" count) than there are entries.
  localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  // Reserved encodings 110/111 fall through to the default branch (HOLD).
  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_INCR = 3'b001,
    OP_REL  = 3'b010,
    OP_ABS  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101
  } op_e;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [WIDTH-1:0] pc_step;
  logic [WIDTH-1:0] ras_top;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] pc_next;
  logic [CW-1:0]    cnt_next;
  logic             push;
  logic             set_ovf;
  logic             set_unf;

  // The stack pointer is ras_count itself: push writes at ras_count,
  // the top entry lives at ras_count-1.
  assign pc_step   = pc + WIDTH'(STEP);
  assign push_idx  = AW'(ras_count);
  assign top_idx   = AW'(ras_count - 1'b1);
  assign ras_top   = ras_mem[top_idx];
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);

  // Next-PC selection, stack pointer update and error-event decode.
  always_comb begin
    pc_next  = pc;
    cnt_next = ras_count;
    push     = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    if (en) begin
      case (op_e'(op))
        OP_INCR: pc_next = pc_step;
        OP_REL:  pc_next = decr ? (pc - diff) : (pc + diff);
        OP_ABS:  pc_next = target;
        OP_CALL: begin
          // The jump is taken even when the return address cannot be saved.
          pc_next = target;
          if (!ras_full) begin
            push     = 1'b1;
            cnt_next = ras_count + 1'b1;
          end else begin
            set_ovf = 1'b1;
          end
        end
        OP_RET: begin
          if (!ras_empty) begin
            pc_next  = ras_top;
            cnt_next = ras_count - 1'b1;
          end else begin
            // Nothing to return to: fall through to the next instruction.
            pc_next = pc_step;
            set_unf = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // PC, stack pointer and sticky error flags; a new error beats clr_err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_VEC;
      ras_count <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
    end else begin
      pc        <= pc_next;
      ras_count <= cnt_next;
      err_ovf   <= set_ovf | (err_ovf & ~clr_err);
      err_unf   <= set_unf | (err_unf & ~clr_err);
    end
  end

  // Stack storage needs no reset: entries above ras_count are never read.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      ras_mem[push_idx] <= pc_step;
    end
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit. It holds the PC register and computes the next PC for sequential fetch, sign-magnitude relative branches, absolute jumps, and call/return through an internal return-address stack (RAS). It sits between the decode/control FSM and instruction-memory address generation, and supersedes the stand-alone combinational incrementer. Stack overflow and underflow are reported as sticky error flags.

## Interface
- WIDTH, 16, PC/address width in bits (≥ 4)
- STEP, 1, increment applied on INCR and used for the CALL return address
- RAS_DEPTH, 8, return-address stack entries (≥ 2, power of two not required)
- RESET_VEC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset: synchronous, active-low
- en  in  1  advance enable; when low, PC and RAS hold (stall)
- op  in  3  000 HOLD, 001 INCR, 010 REL, 011 ABS, 100 CALL, 101 RET, 110/111 treated as HOLD
- decr  in  1  REL direction: 1 = subtract diff, 0 = add diff
- diff  in  WIDTH  REL magnitude, unsigned
- target  in  WIDTH  ABS/CALL destination
- clr_err  in  1  clears err_ovf/err_unf; honoured regardless of en
- pc  out  WIDTH  current PC (registered)
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
- ras_full  out  1  ras_count == RAS_DEPTH
- ras_empty  out  1  ras_count == 0
- err_ovf  out  1  sticky: CALL attempted with RAS full
- err_unf  out  1  sticky: RET attempted with RAS empty

## Operation
- All arithmetic is unsigned, modulo 2^WIDTH; wrap-around is silent, with no flag.
- Operations apply when en = 1 at the rising edge:
  - HOLD: pc unchanged.
  - INCR: pc ← pc + STEP.
  - REL: pc ← decr ? pc − diff : pc + diff.
  - ABS: pc ← target.
  - CALL:
    - RAS not full: push (pc + STEP), then pc ← target.
    - RAS full: push is discarded and stack contents are unchanged. The jump is still taken (pc ← target) and err_ovf ← 1.
  - RET:
    - RAS not empty: pc ← top entry, pop.
    - RAS empty: pc ← pc + STEP and err_unf ← 1. The stack stays empty.
- en = 0: pc, RAS contents and ras_count are unchanged, and no error is raised regardless of op.
- RAS is LIFO, implemented as a register array with pointer = ras_count. ras_count only ever changes by ±1 or resets to 0.
- Error flags:
  - Set by the events above; cleared by clr_err or reset.
  - clr_err in the same cycle as a new error event: the set wins, so the flag reads 1 afterwards.
- Reserved ops (110/111) behave exactly as HOLD, with no error.

## Timing
- Single clock domain; every output is registered or a direct decode of registers.
- Latency: op sampled at edge N is reflected on pc, ras_count and the flags immediately after edge N (one cycle). There is no combinational path from inputs to outputs.
- Back-to-back operations are supported every cycle, e.g. CALL then RET on consecutive edges returns to the call site + STEP.
- Reset (rst_n = 0 at a rising edge) overrides en, op and clr_err. It has the following effects:
  - pc ← RESET_VEC
  - ras_count ← 0, ras_empty = 1, ras_full = 0
  - err_ovf = err_unf = 0
  - RAS storage contents are don't-care.
- Reset asserted mid-sequence (e.g. between CALL and RET) discards all stacked return addresses. A subsequent RET underflows.
- Reset values: pc = RESET_VEC, ras_count = 0, ras_empty = 1, ras_full = 0, err_ovf = 0, err_unf = 0.

## Test plan
- Reset/INCR/stall:
  - Release rst_n with RESET_VEC = 0x0100, then INCR ×3 → pc = 0x0101, 0x0102, 0x0103.
  - Drop en for 2 cycles with op = INCR → pc holds 0x0103.
  - Assert reset mid-run → pc = 0x0100 on the next edge.
- REL and wrap (WIDTH = 16):
  - pc = 0x0002, REL decr = 1 diff = 0x0005 → pc = 0xFFFD.
  - REL decr = 0 diff = 0x0010 → pc = 0x000D.
  - pc = 0xFFFF, INCR → pc = 0x0000.
- CALL/RET nesting:
  - From pc = 0x0010: CALL target 0x0200, then CALL 0x0300 → ras_count = 2, pc = 0x0300.
  - RET → pc = 0x0201, then RET → pc = 0x0011, ras_empty = 1.
- Overflow (RAS_DEPTH = 8):
  - 8 CALLs fill the stack (ras_full = 1).
  - 9th CALL target 0x0400 → pc = 0x0400, ras_count stays 8, err_ovf = 1.
  - 8 RETs return the 8 stacked addresses in LIFO order.
- Underflow and clear:
  - RET on empty stack at pc = 0x0050 → pc = 0x0051, err_unf = 1, ras_count = 0.
  - clr_err alone → err_unf = 0.
  - clr_err together with a second empty RET → err_unf stays 1.
- Reserved op and reset during RAS use:
  - op = 111 → pc unchanged, no flags.
  - After 3 CALLs, pulse rst_n low → ras_count = 0, pc = RESET_VEC.
  - The following RET sets err_unf.
